// File: rtl/rat_fetch_predict.sv
// rat_fetch_predict: RAT CPU instruction-fetch stage.
// Owns the PC, predicts each fetched branch from a bimodal table of 2-bit
// saturating counters, and registers fetch results into the IF/ID boundary.
module rat_fetch_predict #(
  parameter int          BHT_BITS = 4,
  parameter logic [9:0]  RESET_PC = 10'h000,
  parameter int          IR_WIDTH = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  output logic [9:0]          prog_addr,
  input  logic [IR_WIDTH-1:0] prog_ir,
  input  logic                pd_is_branch,
  input  logic                pd_is_uncond,
  input  logic [9:0]          pd_target,
  input  logic                ex_update,
  input  logic [9:0]          ex_pc,
  input  logic                ex_taken,
  input  logic                ex_mispredict,
  input  logic [9:0]          ex_redirect_pc,
  output logic [9:0]          out_PC,
  output logic [IR_WIDTH-1:0] out_IR,
  output logic [9:0]          alt_out,
  output logic                branch_taken_out,
  output logic                nop_out
);

  localparam int BHT_SIZE = 1 << BHT_BITS;

  logic [9:0]          pc_q, pc_d;
  logic [1:0]          bht_q [BHT_SIZE];
  logic [1:0]          bht_d [BHT_SIZE];
  logic [9:0]          out_pc_q, out_pc_d;
  logic [IR_WIDTH-1:0] out_ir_q, out_ir_d;
  logic [9:0]          alt_q, alt_d;
  logic                taken_q, taken_d;
  logic                nop_q, nop_d;

  logic [BHT_BITS-1:0] fetch_idx;
  logic [BHT_BITS-1:0] ex_idx;
  logic [9:0]          pc_plus1;
  logic                pred_taken;
  logic [9:0]          next_pc;
  logic [9:0]          alt_addr;

  assign fetch_idx = pc_q[BHT_BITS-1:0];
  assign ex_idx    = ex_pc[BHT_BITS-1:0];
  assign pc_plus1  = pc_q + 10'd1;

  // Prediction on the current PC; the table read sees pre-update contents.
  always_comb begin
    pred_taken = pd_is_branch & (pd_is_uncond | bht_q[fetch_idx][1]);
    next_pc    = pred_taken ? pd_target : pc_plus1;
    if (pred_taken)        alt_addr = pc_plus1;
    else if (pd_is_branch) alt_addr = pd_target;
    else                   alt_addr = 10'h000;
  end

  // PC and IF/ID next state: mispredict flushes and overrides stall.
  always_comb begin
    pc_d     = pc_q;
    out_pc_d = out_pc_q;
    out_ir_d = out_ir_q;
    alt_d    = alt_q;
    taken_d  = taken_q;
    nop_d    = nop_q;
    if (ex_mispredict) begin
      pc_d     = ex_redirect_pc;
      out_pc_d = '0;
      out_ir_d = '0;
      alt_d    = '0;
      taken_d  = 1'b0;
      nop_d    = 1'b1;
    end else if (!stall) begin
      pc_d     = next_pc;
      out_pc_d = pc_q;
      out_ir_d = prog_ir;
      alt_d    = alt_addr;
      taken_d  = pred_taken;
      nop_d    = 1'b0;
    end
  end

  // Saturating counter training from the branch resolver, independent of stall/flush.
  always_comb begin
    bht_d = bht_q;
    if (ex_update) begin
      if (ex_taken && (bht_q[ex_idx] != 2'b11))
        bht_d[ex_idx] = bht_q[ex_idx] + 2'd1;
      else if (!ex_taken && (bht_q[ex_idx] != 2'b00))
        bht_d[ex_idx] = bht_q[ex_idx] - 2'd1;
    end
  end

  // State registers; reset leaves every counter weakly not-taken and IF/ID a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      out_pc_q <= '0;
      out_ir_q <= '0;
      alt_q    <= '0;
      taken_q  <= 1'b0;
      nop_q    <= 1'b1;
      for (int i = 0; i < BHT_SIZE; i++) bht_q[i] <= 2'b01;
    end else begin
      pc_q     <= pc_d;
      out_pc_q <= out_pc_d;
      out_ir_q <= out_ir_d;
      alt_q    <= alt_d;
      taken_q  <= taken_d;
      nop_q    <= nop_d;
      bht_q    <= bht_d;
    end
  end

  assign prog_addr        = pc_q;
  assign out_PC           = out_pc_q;
  assign out_IR           = out_ir_q;
  assign alt_out          = alt_q;
  assign branch_taken_out = taken_q;
  assign nop_out          = nop_q;

endmodule
